// File: rtl/aes_key_schedule.sv
// Purpose : AES-128/192/256 key expansion, one schedule word per cycle, round keys kept in a 60-word buffer.
// Latency : start-to-done 42/48/54 cycles (AES-128/192/256); round-key read is 1 cycle.
// Backpressure: none; start while busy (or key_mode=3) is dropped, reads are gated by key_ready.
//
// Ports: clk/reset (async active-high); key_mode/key_in/start load a key (key left-aligned, w0 = key_in[255:224]);
//        busy/done/key_ready report expansion status; rd_en/rd_round/rd_dec -> rd_key/rd_valid one cycle later.
// Optional feature macro: AES_KEY_SCHED_DECRYPT_EN (rd_dec=1 returns round Nr-rd_round).
module aes_key_schedule #(
    parameter int MAX_KEY_LEN = 256,
    parameter int WORD_LEN    = 32,
    parameter int BLOCK_LEN   = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             key_mode,
    input  logic [MAX_KEY_LEN-1:0] key_in,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   key_ready,
    input  logic                   rd_en,
    input  logic [3:0]             rd_round,
    input  logic                   rd_dec,
    output logic [BLOCK_LEN-1:0]   rd_key,
    output logic                   rd_valid
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EXPAND, ST_FIN} state_t;

    state_t              state, state_nxt;
    logic                accept;
    logic [1:0]          mode_q;
    logic [5:0]          wi;      // index of the word being produced
    logic [2:0]          phase;   // wi mod Nk, kept incrementally to avoid a divider
    logic [7:0]          rcon;
    logic [3:0]          nk, nr;
    logic [5:0]          w_last;
    logic [WORD_LEN-1:0] kbuf [0:59];
    logic [WORD_LEN-1:0] prev_w, old_w, temp, new_w;
    logic                rd_ok;
    logic [3:0]          rd_idx;
    logic [5:0]          rd_base;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (b^254 by square-and-multiply) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq, inv;
        sq  = b;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    assign busy = (state != ST_IDLE);

    // Mode constants follow the stored mode; mode 3 is never stored.
    always_comb begin
        nk     = 4'd8;
        nr     = 4'd14;
        w_last = 6'd59;
        case (mode_q)
            2'd0: begin nk = 4'd4; nr = 4'd10; w_last = 6'd43; end
            2'd1: begin nk = 4'd6; nr = 4'd12; w_last = 6'd51; end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && key_mode != 2'd3) begin
                    accept    = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD:   state_nxt = ST_EXPAND;
            ST_EXPAND: if (wi == w_last) state_nxt = ST_FIN;
            ST_FIN:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Word recurrence: w[i] = w[i-Nk] ^ f(w[i-1]).
    always_comb begin
        prev_w = kbuf[wi - 6'd1];
        old_w  = kbuf[wi - {2'b00, nk}];
        temp   = prev_w;
        if (phase == 3'd0)
            temp = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon, 24'h000000};
        else if (nk == 4'd8 && phase == 3'd4)
            temp = sub_word(prev_w);
        new_w = old_w ^ temp;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            mode_q    <= 2'd0;
            wi        <= 6'd0;
            phase     <= 3'd0;
            rcon      <= 8'h01;
            done      <= 1'b0;
            key_ready <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            if (accept) begin
                mode_q    <= key_mode;
                key_ready <= 1'b0;
            end
            case (state)
                ST_LOAD: begin
                    wi    <= {2'b00, nk};
                    phase <= 3'd0;
                    rcon  <= 8'h01;
                end
                ST_EXPAND: begin
                    wi    <= wi + 6'd1;
                    phase <= (({1'b0, phase} + 4'd1) == nk) ? 3'd0 : phase + 3'd1;
                    if (phase == 3'd0)
                        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                end
                ST_FIN: begin
                    done      <= 1'b1;
                    key_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The key words are captured together with start so key_in need not be held;
    // unused upper words for shorter keys are overwritten by the expansion.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < 8; k++)
                kbuf[k] <= key_in[MAX_KEY_LEN-1-WORD_LEN*k -: WORD_LEN];
        end else if (state == ST_EXPAND) begin
            kbuf[wi] <= new_w;
        end
    end

    // Read port: bounds check is on the requested round, before any reversal.
    always_comb begin
        rd_ok = key_ready && (rd_round <= nr);
`ifdef AES_KEY_SCHED_DECRYPT_EN
        rd_idx = rd_dec ? (nr - rd_round) : rd_round;
`else
        rd_idx = rd_round;
`endif
        rd_base = rd_ok ? {rd_idx, 2'b00} : 6'd0;
    end

`ifndef AES_KEY_SCHED_DECRYPT_EN
    logic unused_rd_dec;
    assign unused_rd_dec = rd_dec;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_key   <= '0;
        end else if (rd_en) begin
            rd_valid <= rd_ok;
            rd_key   <= rd_ok ? {kbuf[rd_base], kbuf[rd_base + 6'd1], kbuf[rd_base + 6'd2], kbuf[rd_base + 6'd3]}
                              : '0;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Purpose : self-checking bench for aes_key_schedule against a word-level FIPS-197 model.
// Latency : model tracks start-to-done and 1-cycle reads per mode.
// Backpressure: n/a (bench drives start/reads freely, including illegal requests).
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   key_mode;
    logic [255:0] key_in;
    logic         start;
    logic         busy, done, key_ready;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic         rd_dec;
    logic [127:0] rd_key;
    logic         rd_valid;

    aes_key_schedule dut (
        .clk(clk), .reset(reset), .key_mode(key_mode), .key_in(key_in), .start(start),
        .busy(busy), .done(done), .key_ready(key_ready), .rd_en(rd_en), .rd_round(rd_round),
        .rd_dec(rd_dec), .rd_key(rd_key), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] K128    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R1_128  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [191:0] K192    = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] R12_192 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] K256    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R14_256 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] R0_256  = 128'h603deb1015ca71be2b73aef0857d7781;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", nm, got, exp);
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  sbt [0:255];
    logic [31:0] m_w [0:59];
    int          m_cnt = 0;
    logic        m_done = 1'b0, m_ready = 1'b0, m_rdv = 1'b0, m_ok;
    logic [127:0] m_rdkey = '0;
    logic [1:0]  m_mode = 2'd0;
    int          m_r;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00, x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse by exhaustive search, then the bitwise affine definition.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00, s;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ ((8'h63 >> i) & 8'h01) != 0;
            sbt[x] = s;
        end
    endtask

    function automatic int nk_of(input logic [1:0] m);
        return (m == 2'd0) ? 4 : (m == 2'd1) ? 6 : 8;
    endfunction
    function automatic int nr_of(input logic [1:0] m);
        return nk_of(m) + 6;
    endfunction
    function automatic int lat_of(input logic [1:0] m);
        return 4 * (nr_of(m) + 1) - nk_of(m) + 2;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
    endfunction

    task automatic expand_model(input logic [255:0] key, input logic [1:0] mode);
        int nk = nk_of(mode);
        int wt = 4 * (nr_of(mode) + 1);
        for (int i = 0; i < 60; i++) m_w[i] = 32'h0;
        for (int i = 0; i < nk; i++) m_w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < wt; i++) begin
            logic [31:0] t = m_w[i-1];
            if (i % nk == 0) begin
                logic [7:0] rc = 8'h01;
                for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk == 8 && i % 8 == 4) begin
                t = subw(t);
            end
            m_w[i] = m_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] model_round(input int r);
        return {m_w[4*r], m_w[4*r+1], m_w[4*r+2], m_w[4*r+3]};
    endfunction

    // Model step on each rising edge, then compare all outputs just after it.
    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0; m_done = 1'b0; m_ready = 1'b0; m_rdv = 1'b0; m_rdkey = '0;
        end else begin
            m_done = 1'b0;
            if (rd_en) begin
                m_r  = int'(rd_round);
                m_ok = m_ready && (m_r <= nr_of(m_mode));
`ifdef AES_KEY_SCHED_DECRYPT_EN
                if (rd_dec) m_r = nr_of(m_mode) - m_r;
`endif
                m_rdv   = m_ok;
                m_rdkey = m_ok ? model_round(m_r) : '0;
            end else begin
                m_rdv = 1'b0;
            end
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin m_done = 1'b1; m_ready = 1'b1; end
            end else if (start && key_mode != 2'd3) begin
                m_cnt   = lat_of(key_mode);
                m_ready = 1'b0;
                m_mode  = key_mode;
                expand_model(key_in, key_mode);
            end
        end
        #1;
        chk("busy",      128'(busy),      128'(m_cnt > 0));
        chk("done",      128'(done),      128'(m_done));
        chk("key_ready", 128'(key_ready), 128'(m_ready));
        chk("rd_valid",  128'(rd_valid),  128'(m_rdv));
        chk("rd_key",    rd_key,          m_rdkey);
    end

    // ---------------- directed + random driver ----------------
    task automatic start_pulse(input logic [1:0] mode, input logic [255:0] key);
        start = 1'b1; key_mode = mode; key_in = key;
        @(negedge clk);
        start = 1'b0; key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    // Counts edges after the accepting edge until done is seen; optionally injects a start while busy.
    task automatic wait_done(input int inject_at, output int lat);
        lat = 0;
        while (!done && lat < 300) begin
            if (lat == inject_at) begin
                start = 1'b1; key_mode = 2'd2;
                key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
    endtask

    task automatic do_read(input logic [3:0] r, input logic dec, output logic v, output logic [127:0] k);
        rd_en = 1'b1; rd_round = r; rd_dec = dec;
        @(negedge clk);
        v = rd_valid; k = rd_key;
        rd_en = 1'b0; rd_dec = 1'b0;
    endtask

    initial begin
        int lat;
        logic v;
        logic [127:0] k;
        reset = 1'b1; start = 1'b0; key_mode = 2'd0; key_in = '0;
        rd_en = 1'b0; rd_round = 4'd0; rd_dec = 1'b0;
        build_sbox();
        chk("model_sbox_00", 128'(sbt[0]),     128'h63);
        chk("model_sbox_53", 128'(sbt[8'h53]), 128'hed);
        repeat (2) @(negedge clk);
        chk("reset_busy",  128'(busy),     128'h0);
        chk("reset_rdkey", rd_key,         128'h0);
        reset = 1'b0;
        @(negedge clk);

        // AES-128
        start_pulse(2'd0, {K128, 128'h0});
        wait_done(-1, lat);
        chk("lat_128", 128'(lat), 128'd42);
        chk("model_r1_128", model_round(1), R1_128);
        do_read(4'd1, 1'b0, v, k);  chk("r1_128", k, R1_128);  chk("r1_128_vld", 128'(v), 128'h1);
        do_read(4'd10, 1'b0, v, k); chk("r10_128", k, R10_128);
        do_read(4'd11, 1'b0, v, k); chk("r11_128_vld", 128'(v), 128'h0); chk("r11_128_key", k, 128'h0);
        do_read(4'd0, 1'b1, v, k);
`ifdef AES_KEY_SCHED_DECRYPT_EN
        chk("dec_r0_128", k, R10_128);
`else
        chk("dec_r0_128", k, K128);
`endif

        // start while busy is ignored
        start_pulse(2'd0, {K128, 128'h0});
        wait_done(10, lat);
        chk("lat_128_busy_start", 128'(lat), 128'd42);
        do_read(4'd10, 1'b0, v, k); chk("r10_128_after_busy_start", k, R10_128);

        // reserved mode
        start_pulse(2'd3, {K256});
        chk("mode3_busy", 128'(busy), 128'h0);

        // AES-192
        start_pulse(2'd1, {K192, 64'h0});
        wait_done(-1, lat);
        chk("lat_192", 128'(lat), 128'd48);
        do_read(4'd12, 1'b0, v, k); chk("r12_192", k, R12_192);

        // AES-256
        start_pulse(2'd2, K256);
        wait_done(-1, lat);
        chk("lat_256", 128'(lat), 128'd54);
        do_read(4'd14, 1'b0, v, k); chk("r14_256", k, R14_256);
        do_read(4'd0, 1'b0, v, k);  chk("r0_256", k, R0_256);

        // reset mid-expansion
        start_pulse(2'd0, {K128, 128'h0});
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy",  128'(busy),      128'h0);
        chk("midrst_ready", 128'(key_ready), 128'h0);
        chk("midrst_done",  128'(done),      128'h0);
        @(negedge clk);
        reset = 1'b0;
        do_read(4'd10, 1'b0, v, k); chk("midrst_read_vld", 128'(v), 128'h0);
        start_pulse(2'd0, {K128, 128'h0});
        wait_done(-1, lat);
        do_read(4'd10, 1'b0, v, k); chk("restart_r10_128", k, R10_128);

        // randomized traffic, checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 999) == 0);
            start    = ($urandom_range(0, 39) == 0);
            key_mode = 2'($urandom_range(0, 3));
            key_in   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rd_en    = 1'($urandom_range(0, 1));
            rd_round = 4'($urandom_range(0, 15));
            rd_dec   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        reset = 1'b0; start = 1'b0; rd_en = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
